convolutional_encoder: RTL and testbench

Rate-1/2, constraint-length-7 convolutional encoder (IEEE 802.11a, polynomials 133/171 octal) with optional puncturing to rate 2/3 and 3/4. It sits directly downstream of `Transmitter`. It consumes the serial frame bitstream one bit per accepted handshake and emits the coded, punctured serial bitstream to the interleaver stage. Flow control on both sides is valid/ready, so the encoder throttles its upstream to the 1-bit-per-cycle output rate.

---
 rtl/convolutional_encoder.sv | 169 ++++++++++++++++
 tb/tb_convolutional_encoder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/convolutional_encoder.sv
`default_nettype none
// ============================================================================
// Module  : convolutional_encoder
// Brief   : 802.11a K=7 rate-1/2 convolutional encoder (133/171 octal) with
//           optional 2/3 and 3/4 puncturing, enabled by CONV_ENCODER_PUNCTURE_EN.
// Revision: 1.0
// ============================================================================
module convolutional_encoder (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Start,
   input  logic [1:0] Rate,
   input  logic       InValid,
   input  logic       Input,
   output logic       InReady,
   output logic       OutValid,
   output logic       Output,
   input  logic       OutReady
);

   localparam logic [6:0] G0        = 7'o133;
   localparam logic [6:0] G1        = 7'o171;
   localparam logic [0:0] S_IDLE    = 1'b0;
   localparam logic [0:0] S_RUN     = 1'b1;
   localparam logic [1:0] RATE_1_2  = 2'b00;
   localparam logic [1:0] RATE_2_3  = 2'b01;
   localparam logic [1:0] RATE_3_4  = 2'b10;

   logic [0:0] state_q, state_d;
   logic [5:0] sr_q, sr_d;      // sr_q[5] = d1 ... sr_q[0] = d6
   logic [1:0] cnt_q, cnt_d;
   logic [1:0] buf_q, buf_d;    // buf_q[0] is the head
   logic [6:0] w_taps;
   logic       w_a, w_b;
   logic       w_first, w_second;
   logic [1:0] w_nload;
   logic       w_accept, w_pop;

   // Tap vector bit (6-k) holds dk, matching the generator bit ordering.
   assign w_taps   = {Input, sr_q};
   assign w_a      = ^(w_taps & G0);
   assign w_b      = ^(w_taps & G1);
   assign w_accept = InValid && InReady;
   assign w_pop    = OutValid && OutReady;
   assign Output   = buf_q[0];

`ifdef CONV_ENCODER_PUNCTURE_EN
   logic [1:0] phase_q, phase_d, w_phase_next;
   logic [1:0] rate_q, rate_d;

   always_comb begin
      w_first      = w_a;
      w_second     = w_b;
      w_nload      = 2'd2;
      w_phase_next = 2'd0;
      case (rate_q)
         RATE_2_3: begin
            if (phase_q == 2'd0) begin
               w_phase_next = 2'd1;
            end else begin
               w_second = 1'b0;
               w_nload  = 2'd1;
            end
         end
         RATE_3_4: begin
            case (phase_q)
               2'd0: w_phase_next = 2'd1;
               2'd1: begin
                  w_second     = 1'b0;
                  w_nload      = 2'd1;
                  w_phase_next = 2'd2;
               end
               default: begin
                  w_first  = w_b;
                  w_second = 1'b0;
                  w_nload  = 2'd1;
               end
            endcase
         end
         default: ;
      endcase
   end

   always_comb begin
      phase_d = phase_q;
      rate_d  = rate_q;
      if (Start) begin
         phase_d = 2'd0;
         rate_d  = Rate;
      end else if (w_accept) begin
         phase_d = w_phase_next;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         phase_q <= 2'd0;
         rate_q  <= RATE_1_2;
      end else begin
         phase_q <= phase_d;
         rate_q  <= rate_d;
      end
   end
`else
   logic unused_rate;
   assign unused_rate = ^Rate;
   assign w_first     = w_a;
   assign w_second    = w_b;
   assign w_nload     = 2'd2;
`endif

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (Start) begin
         state_d = S_RUN;
      end
   end

   always_comb begin
      InReady  = 1'b0;
      OutValid = 1'b0;
      if (state_q == S_RUN) begin
         InReady  = !Start && ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && OutReady));
         OutValid = (cnt_q != 2'd0);
      end
   end

   // An accept only happens with the buffer empty or its last bit leaving,
   // so new bits always land at the head.
   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      buf_d = buf_q;
      if (Start) begin
         sr_d  = 6'd0;
         cnt_d = 2'd0;
         buf_d = 2'd0;
      end else if (w_accept) begin
         sr_d  = {Input, sr_q[5:1]};
         buf_d = {w_second, w_first};
         cnt_d = w_nload;
      end else if (w_pop) begin
         buf_d = {1'b0, buf_q[1]};
         cnt_d = cnt_q - 2'd1;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         sr_q  <= 6'd0;
         cnt_q <= 2'd0;
         buf_q <= 2'd0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
         buf_q <= buf_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_convolutional_encoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_convolutional_encoder
// Brief   : Scoreboard bench for convolutional_encoder (handshake, streams,
//           stall, restart, reset).
// Revision: 1.0
// ============================================================================
module tb_convolutional_encoder;

   logic       Clock = 1'b0;
   logic       Reset, Start, InValid, Input, OutReady;
   logic [1:0] Rate;
   logic       InReady, OutValid, Output;

   int          checks = 0;
   int          errors = 0;
   bit          q[$];
   logic [5:0]  m_sr;        // m_sr[5] = d1 ... m_sr[0] = d6
   int          m_phase;
   logic [1:0]  m_rate;
   bit          m_run;
   logic [63:0] got;
   int          nsteps;

   always #5 Clock = ~Clock;

   convolutional_encoder dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .Start    (Start),
      .Rate     (Rate),
      .InValid  (InValid),
      .Input    (Input),
      .InReady  (InReady),
      .OutValid (OutValid),
      .Output   (Output),
      .OutReady (OutReady)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_accept(input bit d);
      bit a, b;
      a = d ^ m_sr[4] ^ m_sr[3] ^ m_sr[1] ^ m_sr[0];
      b = d ^ m_sr[5] ^ m_sr[4] ^ m_sr[3] ^ m_sr[0];
      case (m_rate)
         2'b01: begin
            if (m_phase == 0) begin q.push_back(a); q.push_back(b); m_phase = 1; end
            else begin q.push_back(a); m_phase = 0; end
         end
         2'b10: begin
            if (m_phase == 0) begin q.push_back(a); q.push_back(b); m_phase = 1; end
            else if (m_phase == 1) begin q.push_back(a); m_phase = 2; end
            else begin q.push_back(b); m_phase = 0; end
         end
         default: begin q.push_back(a); q.push_back(b); end
      endcase
      m_sr = {d, m_sr[5:1]};
   endtask

   // One clock: check outputs mid-cycle, advance the model, return accept.
   task automatic step(input string tag, output bit acc);
      bit exp_rdy, exp_val, pop;
      @(negedge Clock);
      exp_val = m_run && (q.size() != 0);
      exp_rdy = m_run && !Start && ((q.size() == 0) || ((q.size() == 1) && OutReady));
      check({tag, ".InReady"}, 64'(InReady), 64'(exp_rdy));
      check({tag, ".OutValid"}, 64'(OutValid), 64'(exp_val));
      if (exp_val) check({tag, ".Output"}, 64'(Output), 64'(q[0]));
      pop = exp_val && OutReady;
      acc = InValid && exp_rdy && !Reset;
      if (Reset) begin
         q.delete(); m_sr = '0; m_phase = 0; m_rate = 2'b00; m_run = 1'b0;
      end else if (Start) begin
         q.delete(); m_sr = '0; m_phase = 0; m_run = 1'b1;
`ifdef CONV_ENCODER_PUNCTURE_EN
         m_rate = (Rate == 2'b11) ? 2'b00 : Rate;
`else
         m_rate = 2'b00;
`endif
      end else begin
         if (pop) begin
            got = {got[62:0], Output};
            void'(q.pop_front());
         end
         if (acc) model_accept(Input);
      end
      @(posedge Clock);
      #1;
   endtask

   task automatic do_start(input logic [1:0] r);
      bit acc;
      Rate = r; Start = 1'b1;
      step("start", acc);
      Start = 1'b0;
      got = '0;
   endtask

   // Offer n bits (MSB first) until all accepted; nsteps reports cycles used.
   task automatic feed(input string tag, input logic [31:0] bits, input int n);
      bit acc;
      int idx = 0;
      nsteps = 0;
      InValid = 1'b1;
      while (idx < n && nsteps < 40) begin
         Input = bits[n-1-idx];
         step(tag, acc);
         nsteps++;
         if (acc) idx++;
      end
      InValid = 1'b0;
      if (idx < n) check({tag, ".timeout"}, 64'(idx), 64'(n));
   endtask

   task automatic drain(input string tag);
      bit acc;
      int n = 0;
      OutReady = 1'b1;
      InValid  = 1'b0;
      while (q.size() != 0 && n < 20) begin
         step(tag, acc);
         n++;
      end
      if (q.size() != 0) check({tag, ".drain_timeout"}, 64'(q.size()), 64'd0);
   endtask

   initial begin
      bit acc;
      Reset = 1'b1; Start = 1'b0; Rate = 2'b00; InValid = 1'b0; Input = 1'b0; OutReady = 1'b1;
      q.delete(); m_sr = '0; m_phase = 0; m_rate = 2'b00; m_run = 1'b0; got = '0;
      repeat (2) @(posedge Clock);
      #1;
      check("reset.Output", 64'(Output), 64'd0);
      check("reset.OutValid", 64'(OutValid), 64'd0);
      check("reset.InReady", 64'(InReady), 64'd0);
      Reset = 1'b0;

      // Rate 1/2, seven ones, no bubbles
      do_start(2'b00);
      feed("r12", 32'h7F, 7);
      check("r12.cycles", 64'(nsteps), 64'd13);
      drain("r12");
      check("r12.stream", got, 64'b11_10_01_10_10_00_11);

      // Rate 2/3, four ones
      do_start(2'b01);
      feed("r23", 32'hF, 4);
`ifdef CONV_ENCODER_PUNCTURE_EN
      check("r23.cycles", 64'(nsteps), 64'd6);
      drain("r23");
      check("r23.stream", got, 64'b111011);
`else
      check("r23.cycles", 64'(nsteps), 64'd7);
      drain("r23");
      check("r23.stream", got, 64'b11100110);
`endif

      // Rate 3/4, four ones (fourth lands after phase wrap)
      do_start(2'b10);
      feed("r34", 32'hF, 4);
`ifdef CONV_ENCODER_PUNCTURE_EN
      check("r34.cycles", 64'(nsteps), 64'd5);
      drain("r34");
      check("r34.stream", got, 64'b111110);
`else
      check("r34.cycles", 64'(nsteps), 64'd7);
      drain("r34");
      check("r34.stream", got, 64'b11100110);
`endif

      // Backpressure mid-stream; Rate change outside Start ignored
      do_start(2'b00);
      Rate = 2'b01;
      feed("stall.a", 32'h7, 3);
      OutReady = 1'b0;
      InValid  = 1'b1;
      Input    = 1'b1;
      repeat (5) step("stall.hold", acc);
      check("stall.InReady", 64'(InReady), 64'd0);
      check("stall.OutValid", 64'(OutValid), 64'd1);
      OutReady = 1'b1;
      feed("stall.b", 32'hF, 4);
      drain("stall");
      check("stall.stream", got, 64'b11_10_01_10_10_00_11);

      // Start with two pending bits discards them and clears history
      do_start(2'b00);
      feed("flush.a", 32'h1, 1);
      OutReady = 1'b0;
      do_start(2'b00);
      check("flush.OutValid", 64'(OutValid), 64'd0);
      OutReady = 1'b1;
      feed("flush.b", 32'h1, 1);
      drain("flush");
      check("flush.stream", got, 64'b11);

      // Reset mid-frame, then InValid without Start
      do_start(2'b00);
      feed("rst.a", 32'h5, 3);
      Reset = 1'b1;
      step("rst.pulse", acc);
      Reset = 1'b0;
      InValid = 1'b1;
      Input = 1'b1;
      repeat (4) step("rst.idle", acc);
      check("rst.InReady", 64'(InReady), 64'd0);
      check("rst.OutValid", 64'(OutValid), 64'd0);
      InValid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
